alu_uart_interface: RTL and testbench

- Sits between the UART receiver/transmitter and the combinational alu.
- Collects three received bytes in order: operand A, operand B, opcode. Drives them to the alu and captures its result.
- Hands the result byte to the UART transmitter with a one-cycle start pulse, then waits for transmit completion before accepting the next command.

---
 rtl/alu_uart_interface_pkg.sv | 22 ++
 rtl/alu_uart_interface.sv | 82 ++++++++
 tb/tb_alu_uart_interface.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/alu_uart_interface_pkg.sv
// Shared definitions for the UART-to-alu command interface: FSM state
// encoding and the alu opcode values carried in the third command byte.
package alu_uart_interface_pkg;

  typedef enum logic [2:0] {
    GET_A   = 3'd0,
    GET_B   = 3'd1,
    GET_OP  = 3'd2,
    LATCH   = 3'd3,
    WAIT_TX = 3'd4
  } state_t;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;

endpackage

// File: rtl/alu_uart_interface.sv
// Assembles A, B and opcode from received UART bytes, presents them to the alu
// and hands the result byte to the transmitter.
//
// state   | meaning
// GET_A   | waiting for operand A byte
// GET_B   | waiting for operand B byte
// GET_OP  | waiting for opcode byte
// LATCH   | alu result valid; capture it and pulse tx_start
// WAIT_TX | transmit in progress; wait for tx_done_tick
module alu_uart_interface
  import alu_uart_interface_pkg::*;
#(
  parameter int length   = 8,
  parameter int op_width = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          rx_data,
  input  logic                rx_done_tick,
  input  logic                tx_done_tick,
  input  logic [length-1:0]   alu_result,
  output logic [length-1:0]   busA,
  output logic [length-1:0]   busB,
  output logic [op_width-1:0] op,
  output logic [7:0]          tx_data,
  output logic                tx_start,
  output logic                busy,
  output logic                overrun
);

  state_t state;

  assign busy = (state == LATCH) || (state == WAIT_TX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= GET_A;
      busA     <= '0;
      busB     <= '0;
      op       <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      overrun  <= 1'b0;
      case (state)
        GET_A: begin
          if (rx_done_tick) begin
            busA  <= rx_data[length-1:0];
            state <= GET_B;
          end
        end
        GET_B: begin
          if (rx_done_tick) begin
            busB  <= rx_data[length-1:0];
            state <= GET_OP;
          end
        end
        GET_OP: begin
          if (rx_done_tick) begin
            op    <= rx_data[op_width-1:0];
            state <= LATCH;
          end
        end
        LATCH: begin
          // alu_result is unsigned at this port, so the cast zero-extends
          tx_data  <= 8'(alu_result);
          tx_start <= 1'b1;
          overrun  <= rx_done_tick;
          state    <= WAIT_TX;
        end
        WAIT_TX: begin
          overrun <= rx_done_tick;
          if (tx_done_tick) state <= GET_A;
        end
        default: state <= GET_A;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_uart_interface.sv
// Directed bench for alu_uart_interface with a behavioural alu attached.
module tb_alu_uart_interface;
  import alu_uart_interface_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_done_tick;
  logic       tx_done_tick;
  logic [7:0] alu_result;
  logic [7:0] busA, busB, tx_data;
  logic [5:0] op;
  logic       tx_start, busy, overrun;

  int n_vec = 0;
  int n_err = 0;
  int n_tx  = 0;

  always #5 clk = ~clk;

  alu_uart_interface #(.length(8), .op_width(6)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done_tick(rx_done_tick),
    .tx_done_tick(tx_done_tick), .alu_result(alu_result), .busA(busA),
    .busB(busB), .op(op), .tx_data(tx_data), .tx_start(tx_start),
    .busy(busy), .overrun(overrun)
  );

  always_comb begin
    alu_result = 8'h00;
    case (op)
      OP_ADD: alu_result = busA + busB;
      OP_SUB: alu_result = busA - busB;
      OP_AND: alu_result = busA & busB;
      OP_OR:  alu_result = busA | busB;
      OP_XOR: alu_result = busA ^ busB;
      OP_SRA: alu_result = $signed(busA) >>> busB;
      OP_SRL: alu_result = busA >> busB;
      OP_NOR: alu_result = ~(busA | busB);
      default: alu_result = 8'h00;
    endcase
  end

  always @(posedge clk) if (tx_start) n_tx++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data      = b;
    rx_done_tick = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0;
  endtask

  task automatic pulse_tx_done();
    tx_done_tick = 1'b1;
    @(negedge clk);
    tx_done_tick = 1'b0;
  endtask

  // Sends a full command and checks the tx handshake; leaves the DUT in WAIT_TX.
  task automatic send_cmd(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] opb, input logic [7:0] exp);
    int tx0;
    tx0 = n_tx;
    send_byte(a);
    send_byte(b);
    send_byte(opb);
    chk({tag, "_latch_busy"}, busy, 1);
    chk({tag, "_latch_start"}, tx_start, 0);
    @(negedge clk);
    chk({tag, "_start"}, tx_start, 1);
    chk({tag, "_data"}, tx_data, exp);
    @(negedge clk);
    chk({tag, "_start_fall"}, tx_start, 0);
    chk({tag, "_wait_busy"}, busy, 1);
    chk({tag, "_one_pulse"}, n_tx - tx0, 1);
  endtask

  task automatic run_cmd(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] opb, input logic [7:0] exp);
    send_cmd(tag, a, b, opb, exp);
    repeat (2) @(negedge clk);
    chk({tag, "_hold_busy"}, busy, 1);
    pulse_tx_done();
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_data_hold"}, tx_data, exp);
  endtask

  initial begin
    int tx0;
    reset        = 1'b1;
    rx_data      = 8'h00;
    rx_done_tick = 1'b0;
    tx_done_tick = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_busA", busA, 0);
    chk("rst_busB", busB, 0);
    chk("rst_op", op, 0);
    chk("rst_txdata", tx_data, 0);
    chk("rst_txstart", tx_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);

    run_cmd("add", 8'h05, 8'h03, 8'h20, 8'h08);
    chk("add_op", op, 6'h20);
    run_cmd("sub", 8'h03, 8'h05, 8'h22, 8'hFE);
    run_cmd("sra", 8'h80, 8'h01, 8'h03, 8'hC0);
    run_cmd("srl", 8'h80, 8'h01, 8'h02, 8'h40);
    run_cmd("or_hi", 8'h0C, 8'h03, 8'hE5, 8'h0F);
    chk("or_hi_op", op, 6'b100101);
    run_cmd("nor", 8'h0F, 8'h30, 8'h27, 8'hC0);
    run_cmd("unk", 8'h12, 8'h34, 8'h3F, 8'h00);

    // dropped byte while waiting for the transmitter
    send_cmd("ovr", 8'h05, 8'h03, 8'h20, 8'h08);
    rx_data = 8'h7F; rx_done_tick = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0;
    chk("ovr_pulse", overrun, 1);
    chk("ovr_busA", busA, 8'h05);
    chk("ovr_busy", busy, 1);
    @(negedge clk);
    chk("ovr_fall", overrun, 0);
    pulse_tx_done();
    run_cmd("ovr_next", 8'h02, 8'h04, 8'h26, 8'h06);
    chk("ovr_next_busA", busA, 8'h02);

    // dropped byte during LATCH
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h20);
    rx_data = 8'h55; rx_done_tick = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0;
    chk("ovl_pulse", overrun, 1);
    chk("ovl_start", tx_start, 1);
    chk("ovl_data", tx_data, 8'h03);
    chk("ovl_busA", busA, 8'h01);
    pulse_tx_done();
    chk("ovl_idle", busy, 0);

    // reset mid-command
    send_byte(8'h11);
    send_byte(8'h22);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mrst_busA", busA, 0);
    chk("mrst_busB", busB, 0);
    chk("mrst_busy", busy, 0);
    run_cmd("mrst_next", 8'h01, 8'h01, 8'h20, 8'h02);

    // reset mid-transmit
    send_cmd("trst", 8'h07, 8'h01, 8'h20, 8'h08);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("trst_busy", busy, 0);
    chk("trst_txdata", tx_data, 0);

    // rx and tx done together in WAIT_TX
    send_cmd("both", 8'h0A, 8'h05, 8'h24, 8'h00);
    tx0 = n_tx;
    rx_data = 8'h7F; rx_done_tick = 1'b1; tx_done_tick = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0; tx_done_tick = 1'b0;
    chk("both_overrun", overrun, 1);
    chk("both_busy", busy, 0);
    chk("both_busA", busA, 8'h0A);
    chk("both_no_start", tx_start, 0);
    @(negedge clk);
    chk("both_no_pulse", n_tx - tx0, 0);

    // stray tx_done outside WAIT_TX
    pulse_tx_done();
    chk("stray_busy", busy, 0);
    run_cmd("after", 8'h09, 8'h01, 8'h20, 8'h0A);
    chk("after_busA", busA, 8'h09);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
